// File: rtl/encap_pkg.sv
// Shared types and default widths for the Encap_Head parameter scheduler.
package encap_pkg;
  localparam int HEAD_SHIFT_W_D = 6;
  localparam int META_SHIFT_W_D = 7;
  localparam int ENCAP_W_D      = 32;
  localparam int RULE_NUM_D     = 16;
  localparam int CMD_DEPTH_D    = 4;
  localparam int RIDX_W_D       = $clog2(RULE_NUM_D);

  // Field order matches the cfg write bus, MSB first.
  typedef struct packed {
    logic [3:0]                metaSliceOffset;
    logic [HEAD_SHIFT_W_D-1:0] metaDataOffset;
    logic [HEAD_SHIFT_W_D-1:0] headShift;
    logic [META_SHIFT_W_D-1:0] encapLength;
    logic [ENCAP_W_D-1:0]      encapField;
  } encap_rule_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, ARMED} sched_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/encap_cmd_fifo.sv
// Small synchronous FIFO holding pending rule indices.
module encap_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/encap_cmd_sched.sv
// Per-packet rule lookup and parameter arming for Encap_Head, with miss bypass.
module encap_cmd_sched
  import encap_pkg::*;
#(
  parameter  int HEAD_SHIFT_W = HEAD_SHIFT_W_D,
  parameter  int META_SHIFT_W = META_SHIFT_W_D,
  parameter  int ENCAP_W      = ENCAP_W_D,
  parameter  int RULE_NUM     = RULE_NUM_D,
  parameter  int CMD_DEPTH    = CMD_DEPTH_D,
  localparam int RIDX_W       = $clog2(RULE_NUM),
  localparam int CFG_W        = 4 + 2*HEAD_SHIFT_W + META_SHIFT_W + ENCAP_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  input  logic [RIDX_W-1:0]       i_cmd_rule,
  output logic                    o_cmd_ready,
  input  logic                    i_cfg_wren,
  input  logic [RIDX_W-1:0]       i_cfg_addr,
  input  logic [CFG_W-1:0]        i_cfg_data,
  input  logic                    i_head_start,
  output logic                    o_hold,
  output logic [HEAD_SHIFT_W-1:0] o_headShift,
  output logic [3:0]              o_metaSliceOffset,
  output logic [HEAD_SHIFT_W-1:0] o_metaDataOffset,
  output logic [META_SHIFT_W-1:0] o_encapLength,
  output logic [ENCAP_W-1:0]      o_encapField,
  output logic                    o_miss,
  output logic [15:0]             o_pkt_cnt,
  output logic [15:0]             o_miss_cnt
);
  sched_state_e      state_q;
  logic [RIDX_W-1:0] rule_q;
  logic [CFG_W-1:0]  par_q;
  logic [CFG_W-1:0]  tbl_q [RULE_NUM];
  logic [CFG_W-1:0]  out_v;
  logic [RIDX_W-1:0] fifo_data;
  logic              fifo_full, fifo_empty, pop, miss_now;
  logic              miss_q;
  logic [15:0]       pkt_cnt_q, miss_cnt_q;

  encap_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(RIDX_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_data  (i_cmd_rule),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_cmd_ready = i_rst || !fifo_full;
  assign o_hold      = i_rst || (state_q != ARMED);
  assign miss_now    = !i_rst && i_head_start && (state_q != ARMED);
  assign pop         = !i_rst && !fifo_empty &&
                       ((state_q == IDLE) || (state_q == ARMED && i_head_start));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RULE_NUM; i++) tbl_q[i] <= '0;
    end else if (i_cfg_wren) begin
      tbl_q[i_cfg_addr] <= i_cfg_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rule_q     <= '0;
      par_q      <= '0;
      miss_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      miss_q <= miss_now;
      if (miss_now) miss_cnt_q <= sat_inc(miss_cnt_q);
      case (state_q)
        IDLE: if (!fifo_empty) begin
          rule_q  <= fifo_data;
          state_q <= LOOKUP;
        end
        // Table read sees the pre-write value if cfg hits this index now.
        LOOKUP: begin
          par_q   <= tbl_q[rule_q];
          state_q <= ARMED;
        end
        ARMED: if (i_head_start) begin
          pkt_cnt_q <= sat_inc(pkt_cnt_q);
          if (!fifo_empty) begin
            rule_q  <= fifo_data;
            state_q <= LOOKUP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A start with nothing armed falls back to rule 0 for that slice only.
  assign out_v = miss_now ? tbl_q[0] : par_q;

  assign o_encapField      = out_v[ENCAP_W-1:0];
  assign o_encapLength     = out_v[ENCAP_W +: META_SHIFT_W];
  assign o_headShift       = out_v[ENCAP_W+META_SHIFT_W +: HEAD_SHIFT_W];
  assign o_metaDataOffset  = out_v[ENCAP_W+META_SHIFT_W+HEAD_SHIFT_W +: HEAD_SHIFT_W];
  assign o_metaSliceOffset = out_v[CFG_W-1 -: 4];
  assign o_miss            = miss_q;
  assign o_pkt_cnt         = pkt_cnt_q;
  assign o_miss_cnt        = miss_cnt_q;
endmodule

// File: tb/tb_encap_cmd_sched.sv
// Randomized self-checking bench for encap_cmd_sched against a rule-table/queue model.
module tb_encap_cmd_sched;
  import encap_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_cmd_valid, i_cfg_wren, i_head_start;
  logic [3:0]  i_cmd_rule, i_cfg_addr;
  logic [54:0] i_cfg_data;
  logic        o_cmd_ready, o_hold, o_miss;
  logic [5:0]  o_headShift, o_metaDataOffset;
  logic [3:0]  o_metaSliceOffset;
  logic [6:0]  o_encapLength;
  logic [31:0] o_encapField;
  logic [15:0] o_pkt_cnt, o_miss_cnt;

  int tests = 0, fails = 0;
  int mpkt = 0, mmiss = 0;
  encap_rule_t mtbl [16];
  encap_rule_t got;
  assign got = {o_metaSliceOffset, o_metaDataOffset, o_headShift, o_encapLength, o_encapField};

  always #5 i_clk = ~i_clk;

  encap_cmd_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd_rule(i_cmd_rule),
    .o_cmd_ready(o_cmd_ready), .i_cfg_wren(i_cfg_wren), .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data), .i_head_start(i_head_start), .o_hold(o_hold),
    .o_headShift(o_headShift), .o_metaSliceOffset(o_metaSliceOffset),
    .o_metaDataOffset(o_metaDataOffset), .o_encapLength(o_encapLength),
    .o_encapField(o_encapField), .o_miss(o_miss), .o_pkt_cnt(o_pkt_cnt),
    .o_miss_cnt(o_miss_cnt)
  );

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  function automatic encap_rule_t rand_rule();
    encap_rule_t r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1; i_cmd_valid = 0; i_cfg_wren = 0; i_head_start = 0;
    i_cmd_rule = '0; i_cfg_addr = '0; i_cfg_data = '0;
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 16; i++) mtbl[i] = '0;
    mpkt = 0; mmiss = 0;
  endtask

  task automatic cfg_write(input int a, input encap_rule_t r);
    i_cfg_wren = 1; i_cfg_addr = 4'(a); i_cfg_data = r;
    tick();
    i_cfg_wren = 0;
    mtbl[a] = r;
  endtask

  task automatic push(input int a);
    i_cmd_valid = 1; i_cmd_rule = 4'(a);
    tick();
    i_cmd_valid = 0;
  endtask

  task automatic start_pkt();
    i_head_start = 1;
    tick();
    i_head_start = 0;
    mpkt++;
  endtask

  task automatic wait_armed(input string nm);
    for (int i = 0; i < 12 && o_hold; i++) tick();
    tests++;
    if (o_hold !== 1'b0) begin
      $display("FAIL %s armed timeout: hold=%b want 0", nm, o_hold); fails++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1; i_cmd_valid = 0; i_cfg_wren = 0; i_head_start = 0;
    i_cmd_rule = '0; i_cfg_addr = '0; i_cfg_data = '0;
    tick();
    tests++;
    if (o_cmd_ready !== 1'b1 || o_hold !== 1'b1) begin
      $display("FAIL reset_during: ready=%b hold=%b want 1 1", o_cmd_ready, o_hold); fails++;
    end
    i_rst = 0; #1;
    for (int i = 0; i < 16; i++) mtbl[i] = '0;
    tests++;
    if (got !== '0 || o_pkt_cnt !== 0 || o_miss_cnt !== 0 || o_miss !== 0 || o_hold !== 1 || o_cmd_ready !== 1) begin
      $display("FAIL reset_state: params=%h pkt=%0d miss=%0d/%b hold=%b ready=%b",
               got, o_pkt_cnt, o_miss_cnt, o_miss, o_hold, o_cmd_ready); fails++;
    end
    i_head_start = 1; #1;
    tests++;
    if (got !== '0) begin $display("FAIL idle_miss_params: got %h want 0", got); fails++; end
    tick(); i_head_start = 0; mmiss++;
    tests++;
    if (o_miss !== 1'b1 || o_miss_cnt !== 16'(mmiss)) begin
      $display("FAIL idle_miss: miss=%b cnt=%0d want 1 %0d", o_miss, o_miss_cnt, mmiss); fails++;
    end
    tick();
    tests++;
    if (o_miss !== 1'b0) begin $display("FAIL miss_pulse: miss=%b want 0", o_miss); fails++; end
  endtask

  task automatic test_single();
    encap_rule_t r;
    r = '{4'd2, 6'd4, 6'd5, 7'd8, 32'hDEADBEEF};
    cfg_write(3, r);
    push(3);
    tick();
    tests++;
    if (o_hold !== 1'b1) begin $display("FAIL single_lookup_hold: hold=%b want 1", o_hold); fails++; end
    tick();
    tests++;
    if (o_hold !== 1'b0 || got !== r) begin
      $display("FAIL single_armed: hold=%b params=%h want 0 %h", o_hold, got, r); fails++;
    end
    i_head_start = 1; #1;
    tests++;
    if (got !== r) begin $display("FAIL single_start_params: got %h want %h", got, r); fails++; end
    tick(); i_head_start = 0; mpkt++;
    tests++;
    if (o_pkt_cnt !== 16'(mpkt) || o_hold !== 1'b1 || o_miss !== 1'b0) begin
      $display("FAIL single_issue: pkt=%0d hold=%b miss=%b want %0d 1 0", o_pkt_cnt, o_hold, o_miss, mpkt); fails++;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) cfg_write(k, rand_rule());
    cfg_write(9, rand_rule());
    push(9);
    wait_armed("b2b_head");
    for (int k = 1; k <= 4; k++) push(k);
    tests++;
    if (o_cmd_ready !== 1'b0 || got !== mtbl[9]) begin
      $display("FAIL b2b_full: ready=%b params=%h want 0 %h", o_cmd_ready, got, mtbl[9]); fails++;
    end
    start_pkt();
    for (int k = 1; k <= 4; k++) begin
      wait_armed("b2b");
      tests++;
      if (got !== mtbl[k]) begin $display("FAIL b2b_params%0d: got %h want %h", k, got, mtbl[k]); fails++; end
      start_pkt();
    end
    tests++;
    if (o_pkt_cnt !== 16'(mpkt) || o_miss_cnt !== 16'(mmiss)) begin
      $display("FAIL b2b_counts: pkt=%0d miss=%0d want %0d %0d", o_pkt_cnt, o_miss_cnt, mpkt, mmiss); fails++;
    end
  endtask

  task automatic test_write_during_armed();
    encap_rule_t r_old, r_new;
    r_old = rand_rule();
    cfg_write(5, r_old);
    push(5);
    wait_armed("wda");
    r_new = r_old; r_new.encapField = 32'h12345678;
    cfg_write(5, r_new);
    tick();
    tests++;
    if (got !== r_old) begin $display("FAIL wda_hold_old: got %h want %h", got, r_old); fails++; end
    start_pkt();
    push(5);
    wait_armed("wda_next");
    tests++;
    if (got !== r_new || o_encapField !== 32'h12345678) begin
      $display("FAIL wda_new: got %h want %h", got, r_new); fails++;
    end
    start_pkt();
  endtask

  task automatic test_same_cycle();
    encap_rule_t ra, rb;
    ra = rand_rule(); rb = rand_rule();
    cfg_write(6, ra);
    push(6);
    tick();
    tests++;
    if (o_hold !== 1'b1) begin $display("FAIL same_lookup: hold=%b want 1", o_hold); fails++; end
    cfg_write(6, rb);
    tests++;
    if (o_hold !== 1'b0 || got !== ra) begin
      $display("FAIL same_cycle_old: hold=%b got %h want 0 %h", o_hold, got, ra); fails++;
    end
    start_pkt();
    push(6);
    wait_armed("same_next");
    tests++;
    if (got !== rb) begin $display("FAIL same_cycle_new: got %h want %h", got, rb); fails++; end
    start_pkt();
  endtask

  task automatic test_random();
    int q[$];
    int idx, budget;
    for (int i = 0; i < 16; i++) cfg_write(i, rand_rule());
    for (int rnd = 0; rnd < 12; rnd++) begin
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
        idx = int'($urandom_range(0, 15));
        q.push_back(idx);
        push(idx);
      end
      while (q.size() > 0) begin
        budget = 0;
        while (o_hold && budget < 12) begin
          budget++;
          if ($urandom_range(0, 2) == 0) begin
            i_head_start = 1; #1;
            tests++;
            if (got !== mtbl[0]) begin $display("FAIL rnd_bypass: got %h want %h", got, mtbl[0]); fails++; end
            tick(); i_head_start = 0; mmiss++;
            tests++;
            if (o_miss !== 1'b1 || o_miss_cnt !== 16'(mmiss)) begin
              $display("FAIL rnd_miss: miss=%b cnt=%0d want 1 %0d", o_miss, o_miss_cnt, mmiss); fails++;
            end
          end else begin
            tick();
          end
        end
        tests++;
        if (o_hold !== 1'b0) begin
          $display("FAIL rnd_arm_timeout: hold=%b want 0", o_hold); fails++;
          q.delete();
        end else begin
          idx = q.pop_front();
          tests++;
          if (got !== mtbl[idx]) begin $display("FAIL rnd_params rule%0d: got %h want %h", idx, got, mtbl[idx]); fails++; end
          start_pkt();
          tests++;
          if (o_pkt_cnt !== 16'(mpkt)) begin $display("FAIL rnd_pkt_cnt: got %0d want %0d", o_pkt_cnt, mpkt); fails++; end
        end
      end
    end
  endtask

  task automatic test_saturation_and_reset();
    encap_rule_t r7;
    do_reset();
    i_head_start = 1;
    repeat (65540) tick();
    i_head_start = 0;
    tick();
    tests++;
    if (o_miss_cnt !== 16'hFFFF || o_pkt_cnt !== 16'd0) begin
      $display("FAIL miss_saturate: cnt=%h pkt=%0d want ffff 0", o_miss_cnt, o_pkt_cnt); fails++;
    end
    r7 = rand_rule();
    cfg_write(7, r7);
    push(7);
    wait_armed("mid_rst");
    push(7); push(7);
    tests++;
    if (got !== r7) begin $display("FAIL mid_rst_armed: got %h want %h", got, r7); fails++; end
    do_reset();
    tests++;
    if (o_hold !== 1'b1 || o_cmd_ready !== 1'b1 || got !== '0 || o_miss_cnt !== 0 || o_pkt_cnt !== 0) begin
      $display("FAIL mid_rst_state: hold=%b ready=%b params=%h miss=%0d pkt=%0d",
               o_hold, o_cmd_ready, got, o_miss_cnt, o_pkt_cnt); fails++;
    end
    repeat (4) tick();
    tests++;
    if (o_hold !== 1'b1) begin $display("FAIL mid_rst_queue_dropped: hold=%b want 1", o_hold); fails++; end
    i_head_start = 1; #1;
    tests++;
    if (got !== '0) begin $display("FAIL mid_rst_bypass: got %h want 0", got); fails++; end
    tick(); i_head_start = 0;
    tests++;
    if (o_miss !== 1'b1 || o_miss_cnt !== 16'd1 || o_pkt_cnt !== 16'd0) begin
      $display("FAIL mid_rst_miss: miss=%b cnt=%0d pkt=%0d want 1 1 0", o_miss, o_miss_cnt, o_pkt_cnt); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_write_during_armed();
    test_same_cycle();
    test_random();
    test_saturation_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
